// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and bus direction codes for the wait-state memory
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_ctrl_ws_if.sv
// mem_ctrl_ws_if: CPU-side EN/MFC memory bus
interface mem_ctrl_ws_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic EN;
  logic RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;
  logic MFC;
  logic ERR;
  modport master (output EN, RW, addr, Data_in, input Data_out, MFC, ERR);
  modport slave (input EN, RW, addr, Data_in, output Data_out, MFC, ERR);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, registered read of the current address
module mem_array #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: word memory with EN/MFC handshake, read-only low region and wait states
module mem_ctrl_ws
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  parameter int ROM_WORDS = 8,
  parameter logic [DATA_W-1:0] ROM_VAL = '0,
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic rst,
  mem_ctrl_ws_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ROM_L = (ADDR_W+1)'(ROM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t state_q, state_d;
  logic en_q, req_q, req_d, rw_q, rw_d, mfc_q, mfc_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d, rdata;
  logic [3:0] cnt_q, cnt_d;
  logic fire, in_rom, in_ram, we;
  assign fire = state_q == WAIT && cnt_q == 4'd0;
  assign in_rom = {1'b0, addr_q} < ROM_L;
  assign in_ram = {1'b0, addr_q} < DEPTH_L;
  assign we = !rst && fire && rw_q == RW_WRITE && in_ram && !in_rom;
  // In IDLE the RAM already reads the live bus address so read data is ready even at LATENCY=1
  mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk(clk),
    .we(we),
    .addr(state_q == IDLE ? bus.addr[AW-1:0] : addr_q[AW-1:0]),
    .wdata(wdata_q),
    .rdata(rdata)
  );
  always_comb begin
    req_d = bus.EN && !en_q;
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    rw_d = rw_q;
    wdata_d = wdata_q;
    mfc_d = mfc_q;
    err_d = err_q;
    dout_d = dout_q;
    case (state_q)
      IDLE: if (req_q) begin
        addr_d = bus.addr;
        rw_d = bus.RW;
        wdata_d = bus.Data_in;
        cnt_d = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: if (fire) begin
        mfc_d = 1'b1;
        err_d = rw_q == RW_READ ? !in_ram : !in_ram || in_rom;
        dout_d = rw_q != RW_READ ? dout_q : in_rom ? ROM_VAL : in_ram ? rdata : '0;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE: if (!bus.EN) begin
        mfc_d = 1'b0;
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // en_q keeps tracking EN through reset so a level-high EN is never mistaken for a new request
  always_ff @(posedge clk) begin
    en_q <= bus.EN;
    addr_q <= addr_d;
    rw_q <= rw_d;
    wdata_q <= wdata_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      req_q <= 1'b0;
      mfc_q <= 1'b0;
      err_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      mfc_q <= mfc_d;
      err_q <= err_d;
      dout_q <= dout_d;
    end
  end
  assign bus.Data_out = dout_q;
  assign bus.MFC = mfc_q;
  assign bus.ERR = err_q;
endmodule

// File: tb/tb_mem_ctrl_ws.sv
// tb_mem_ctrl_ws: two controllers (LATENCY 1 and 4) on one shared CPU stimulus, checked every cycle
module tb_mem_ctrl_ws;
  localparam int DEPTH = 256;
  localparam int ROMW = 8;
  localparam logic [15:0] ROMV = 16'hA5C3;
  localparam int LAT [2] = '{1, 4};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, rw = 1'b1;
  logic [15:0] a = '0, din = '0;
  always #5 clk = ~clk;
  mem_ctrl_ws_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  mem_ctrl_ws_if #(.ADDR_W(16), .DATA_W(16)) b4 ();
  assign b1.EN = en;
  assign b1.RW = rw;
  assign b1.addr = a;
  assign b1.Data_in = din;
  assign b4.EN = en;
  assign b4.RW = rw;
  assign b4.addr = a;
  assign b4.Data_in = din;
  mem_ctrl_ws #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .ROM_WORDS(ROMW), .ROM_VAL(ROMV), .LATENCY(1))
    u_l1 (.clk(clk), .rst(rst), .bus(b1));
  mem_ctrl_ws #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .ROM_WORDS(ROMW), .ROM_VAL(ROMV), .LATENCY(4))
    u_l4 (.clk(clk), .rst(rst), .bus(b4));

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access accepted at edge t0 completes at edge t0+LAT+1,
  // then its result is held until the first later edge that samples EN low.
  int k = 0, ad;
  bit en_prev = 1'b0;
  bit m_busy [2], m_done [2], m_dk [2];
  int m_tc [2];
  logic m_mfc [2], m_err [2], c_rw [2];
  logic [15:0] m_dout [2], c_a [2], c_d [2];
  logic [15:0] mem_m [2][DEPTH];
  bit known [2][DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_done[i] = 0; m_mfc[i] = 0; m_err[i] = 0; m_dout[i] = 0; m_dk[i] = 1;
      end else if (m_busy[i] && !m_done[i] && k == m_tc[i]) begin
        ad = int'(c_a[i]);
        m_mfc[i] = 1; m_done[i] = 1;
        if (c_rw[i]) begin
          if (ad < ROMW) begin m_dout[i] = ROMV; m_dk[i] = 1; m_err[i] = 0; end
          else if (ad < DEPTH) begin m_dout[i] = mem_m[i][ad]; m_dk[i] = known[i][ad]; m_err[i] = 0; end
          else begin m_dout[i] = 0; m_dk[i] = 1; m_err[i] = 1; end
        end else if (ad >= ROMW && ad < DEPTH) begin
          mem_m[i][ad] = c_d[i]; known[i][ad] = 1; m_err[i] = 0;
        end else m_err[i] = 1;
      end else if (m_done[i] && !en) begin
        m_mfc[i] = 0; m_err[i] = 0; m_done[i] = 0; m_busy[i] = 0;
      end else if (!m_busy[i] && en && !en_prev) begin
        m_busy[i] = 1; m_tc[i] = k + LAT[i] + 1; c_a[i] = a; c_d[i] = din; c_rw[i] = rw;
      end
    end
    en_prev = en;
    k++;
  end

  always @(negedge clk) begin
    check("MFC_L1", 16'(b1.MFC), 16'(m_mfc[0]));
    check("MFC_L4", 16'(b4.MFC), 16'(m_mfc[1]));
    check("ERR_L1", 16'(b1.ERR), 16'(m_err[0]));
    check("ERR_L4", 16'(b4.ERR), 16'(m_err[1]));
    if (m_dk[0]) check("DOUT_L1", b1.Data_out, m_dout[0]);
    if (m_dk[1]) check("DOUT_L4", b4.Data_out, m_dout[1]);
  end

  int fst [2];
  logic [15:0] ld [2];
  logic le [2], am [2];
  task automatic xact(input logic r, input logic [15:0] ad_i, input logic [15:0] d, input int hold, input int gap);
    fst = '{-1, -1};
    @(negedge clk);
    rw = r; a = ad_i; din = d; en = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (c == 2) begin a = 16'($urandom); din = 16'($urandom); rw = 1'($urandom); end
      if (b1.MFC && fst[0] < 0) fst[0] = c;
      if (b4.MFC && fst[1] < 0) fst[1] = c;
    end
    ld = '{b1.Data_out, b4.Data_out};
    le = '{b1.ERR, b4.ERR};
    en = 1'b0;
    for (int c = 0; c < gap; c++) begin
      @(negedge clk);
      if (c == 0) am = '{b1.MFC, b4.MFC};
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 16'($urandom_range(0, 11));
      1: return 16'(16'h00F8 + $urandom_range(0, 15));
      2: return 16'(16'h0010 + $urandom_range(0, 7));
      3: return 16'(16'hFFFF - $urandom_range(0, 2));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("RST_MFC_L1", 16'(b1.MFC), 16'h0);
    check("RST_ERR_L1", 16'(b1.ERR), 16'h0);
    check("RST_DOUT_L1", b1.Data_out, 16'h0);
    check("RST_MFC_L4", 16'(b4.MFC), 16'h0);
    check("RST_ERR_L4", 16'(b4.ERR), 16'h0);
    check("RST_DOUT_L4", b4.Data_out, 16'h0);
    rst = 1'b0;
    xact(1'b0, 16'h0010, 16'hBEEF, 8, 1);
    check("WR_BEEF_ERR", 16'(le[0]), 16'h0);
    xact(1'b1, 16'h0010, 16'h0000, 8, 1);
    check("LAT1_EDGES", 16'(fst[0]), 16'd3);
    check("LAT4_EDGES", 16'(fst[1]), 16'd6);
    check("RD_BEEF_L1", ld[0], 16'hBEEF);
    check("RD_BEEF_L4", ld[1], 16'hBEEF);
    check("RD_BEEF_ERR", 16'(le[0]), 16'h0);
    check("MFC_DROP_L1", 16'(am[0]), 16'h0);
    check("MFC_DROP_L4", 16'(am[1]), 16'h0);
    xact(1'b0, 16'h0003, 16'h1234, 8, 1);
    check("WR_ROM_ERR_L1", 16'(le[0]), 16'h1);
    check("WR_ROM_ERR_L4", 16'(le[1]), 16'h1);
    xact(1'b1, 16'h0003, 16'h0000, 8, 1);
    check("RD_ROM_VAL", ld[0], ROMV);
    check("RD_ROM_ERR", 16'(le[0]), 16'h0);
    xact(1'b1, 16'h0100, 16'h0000, 8, 1);
    check("RD_OOR_DATA", ld[1], 16'h0000);
    check("RD_OOR_ERR", 16'(le[1]), 16'h1);
    xact(1'b0, 16'h00FF, 16'h7777, 8, 1);
    xact(1'b0, 16'hFFFF, 16'hDEAD, 8, 1);
    check("WR_OOR_ERR", 16'(le[0]), 16'h1);
    xact(1'b1, 16'h00FF, 16'h0000, 8, 1);
    check("OOR_NO_ALIAS", ld[0], 16'h7777);
    xact(1'b0, 16'h0020, 16'h5A5A, 8, 1);
    @(negedge clk);
    rw = 1'b0; a = 16'h0020; din = 16'h1111; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("ABORT_MFC_L1", 16'(b1.MFC), 16'h0);
      check("ABORT_MFC_L4", 16'(b4.MFC), 16'h0);
    end
    rst = 1'b0;
    xact(1'b1, 16'h0020, 16'h0000, 8, 1);
    check("ABORT_KEEP_L1", ld[0], 16'h5A5A);
    check("ABORT_KEEP_L4", ld[1], 16'h5A5A);
    for (int n = 0; n < 300; n++)
      xact(1'($urandom), pick_addr(), 16'($urandom), $urandom_range(1, 9), $urandom_range(0, 2));
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
